// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 size/sign codes (F3_*)
//   - FSM state type (used only when LSU_MISALIGNED_EN is defined)
//   - size-mask, legality and natural-alignment decode helpers
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_SPLIT2
  } lsu_state_e;

  // Byte-lane mask for an access of the size encoded in funct3[1:0].
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Offset is a multiple of the access size.
  function automatic logic is_natural(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: CPU-side request/response bundle of the load/store unit.
//   Request : i_req, i_we, i_funct3[2:0], i_addr[9:0], i_wdata[31:0]
//   Response: o_ready, o_rvalid, o_rdata[31:0], o_done, o_fault
//   slave modport  -> the LSU
//   master modport -> the CPU execute stage
interface lsu_if;
  logic        i_req;
  logic        o_ready;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [9:0]  i_addr;
  logic [31:0] i_wdata;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_done;
  logic        o_fault;

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata,
    output o_ready, o_rvalid, o_rdata, o_done, o_fault
  );

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata,
    input  o_ready, o_rvalid, o_rdata, o_done, o_fault
  );
endinterface

// File: rtl/lsu_ldext.sv
// lsu_ldext: load alignment and extension (combinational).
//   i_hi, i_lo  : second and first memory words ({hi, lo} forms a 64-bit window)
//   i_off       : byte offset of the access within the first word
//   i_funct3    : size/sign code
//   o_data      : right-justified, sign- or zero-extended load result
module lsu_ldext
  import lsu_pkg::*;
(
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [63:0] pair;
  logic [31:0] sh;

  always_comb begin
    pair = {i_hi, i_lo};
    sh   = 32'(pair >> {i_off, 3'b000});
    case (i_funct3)
      F3_B:    o_data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    o_data = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   o_data = {24'h000000, sh[7:0]};
      F3_HU:   o_data = {16'h0000, sh[15:0]};
      default: o_data = sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the CPU execute stage and dmem
// (256 x 32-bit words, 10-bit byte address, 1-cycle registered read).
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   cpu          : lsu_if.slave request/response bundle
//   o_mem_we/o_mem_mask/o_mem_addr/o_mem_wdata : dmem write/address drive
//   i_mem_rdata  : dmem read data, valid the cycle after the address
// Compile-time option LSU_MISALIGNED_EN: when defined, non-natural accesses
// are performed (word-crossing ones split over two cycles via SPLIT2);
// when undefined, any non-natural access faults and o_ready is always 1.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        cpu,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_mask,
  output logic [7:0]  o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  logic [1:0]  off;
  logic [7:0]  smask;
  logic        legal;
  logic        accept;
  logic        ready;

  logic        done_d, done_q;
  logic        rvalid_d, rvalid_q;
  logic        fault_d, fault_q;
  logic [1:0]  off_d, off_q;
  logic [2:0]  f3_d, f3_q;

  logic [31:0] ext_hi, ext_lo, ext_data;

`ifdef LSU_MISALIGNED_EN
  lsu_state_e  state_d, state_q;
  logic        crossing;
  logic        split_d, split_q;
  logic        we_d, we_q;
  logic [31:0] wdata_d, wdata_q;
  logic [31:0] lo_d, lo_q;
  logic [7:0]  addr2_d, addr2_q;
  logic [7:0]  smask_q;

  assign ready = (state_q == ST_IDLE);
`else
  logic        natural;

  assign ready = 1'b1;
`endif

  assign accept = cpu.i_req & ready;

  always_comb begin
    off         = cpu.i_addr[1:0];
    legal       = f3_legal(cpu.i_funct3);
    smask       = {4'b0000, size_mask(cpu.i_funct3[1:0])} << off;

    o_mem_we    = 1'b0;
    o_mem_mask  = '0;
    o_mem_addr  = cpu.i_addr[9:2];
    o_mem_wdata = cpu.i_wdata << {off, 3'b000};

    done_d      = 1'b0;
    rvalid_d    = 1'b0;
    fault_d     = 1'b0;
    off_d       = off_q;
    f3_d        = f3_q;

`ifdef LSU_MISALIGNED_EN
    crossing    = |smask[7:4];
    smask_q     = {4'b0000, size_mask(f3_q[1:0])} << off_q;
    state_d     = state_q;
    split_d     = split_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    addr2_d     = addr2_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          off_d   = off;
          f3_d    = cpu.i_funct3;
          split_d = 1'b0;
          if (!legal) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            o_mem_we   = cpu.i_we;
            o_mem_mask = cpu.i_we ? smask[3:0] : 4'b0000;
            if (crossing) begin
              state_d = ST_SPLIT2;
              split_d = 1'b1;
              we_d    = cpu.i_we;
              wdata_d = cpu.i_wdata;
              addr2_d = cpu.i_addr[9:2] + 8'd1;
            end else begin
              done_d   = 1'b1;
              rvalid_d = ~cpu.i_we;
            end
          end
        end
      end
      ST_SPLIT2: begin
        // First-word read data arrives now; hold it so the result can be
        // assembled next cycle when the second word returns.
        lo_d        = i_mem_rdata;
        o_mem_we    = we_q;
        o_mem_mask  = we_q ? smask_q[7:4] : 4'b0000;
        o_mem_addr  = addr2_q;
        o_mem_wdata = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
        done_d      = 1'b1;
        rvalid_d    = ~we_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`else
    natural = is_natural(cpu.i_funct3[1:0], off);
    if (accept) begin
      off_d  = off;
      f3_d   = cpu.i_funct3;
      done_d = 1'b1;
      if (!legal || !natural) begin
        fault_d = 1'b1;
      end else begin
        o_mem_we   = cpu.i_we;
        o_mem_mask = cpu.i_we ? smask[3:0] : 4'b0000;
        rvalid_d   = ~cpu.i_we;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      off_q    <= '0;
      f3_q     <= '0;
`ifdef LSU_MISALIGNED_EN
      state_q  <= ST_IDLE;
      split_q  <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      lo_q     <= '0;
      addr2_q  <= '0;
`endif
    end else begin
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      fault_q  <= fault_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
`ifdef LSU_MISALIGNED_EN
      state_q  <= state_d;
      split_q  <= split_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      lo_q     <= lo_d;
      addr2_q  <= addr2_d;
`endif
    end
  end

`ifdef LSU_MISALIGNED_EN
  assign ext_hi = split_q ? i_mem_rdata : '0;
  assign ext_lo = split_q ? lo_q : i_mem_rdata;
`else
  assign ext_hi = '0;
  assign ext_lo = i_mem_rdata;
`endif

  lsu_ldext u_ldext (
    .i_hi     (ext_hi),
    .i_lo     (ext_lo),
    .i_off    (off_q),
    .i_funct3 (f3_q),
    .o_data   (ext_data)
  );

  assign cpu.o_ready  = ready;
  assign cpu.o_done   = done_q;
  assign cpu.o_rvalid = rvalid_q;
  assign cpu.o_fault  = fault_q;
  assign cpu.o_rdata  = rvalid_q ? ext_data : '0;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the CPU execute stage and the `dmem` data memory. Takes RV32I load/store requests with byte addresses and `funct3` size/sign codes, and turns each into word accesses with a byte-enable mask and lane-shifted write data. Aligns and sign- or zero-extends the word that `dmem` returns one cycle later. Detects misaligned and illegal requests; word-crossing accesses are either split into two accesses or faulted, depending on a compile-time option.

## Interface
Parameters: none (memory fixed at 256 × 32-bit words, 10-bit byte address).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_req` in 1: request valid; accepted when `i_req & o_ready`.
- `o_ready` out 1: LSU can accept a request this cycle.
- `i_we` in 1: 1 = store, 0 = load.
- `i_funct3` in 3: size/sign code. 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other value is illegal.
- `i_addr` in 10: byte address.
- `i_wdata` in 32: store data, right-justified.
- `o_rvalid` out 1: load data valid (1-cycle pulse).
- `o_rdata` out 32: aligned, extended load data.
- `o_done` out 1: request completed (1-cycle pulse; loads, stores, and faults).
- `o_fault` out 1: request faulted; coincides with `o_done`.
- `o_mem_we` out 1: to `dmem` `i_we`.
- `o_mem_mask` out 4: to `dmem` `i_mask`.
- `o_mem_addr` out 8: to `dmem` `i_addr` (word index).
- `o_mem_wdata` out 32: to `dmem` `i_data`.
- `i_mem_rdata` in 32: from `dmem` `o_data`; valid the cycle after the address is presented.

## Operation
- Decode: offset = `addr[1:0]`. Size is 1, 2, or 4 bytes. "Natural" means offset is a multiple of size. "Crossing" means offset + size > 4.
- Memory drive is combinational in the cycle of acceptance; `dmem` registers it on the next edge.
- When no memory access is made: `o_mem_we` = 0 and `o_mem_mask` = 0. `o_mem_addr` and `o_mem_wdata` are don't-care.
- Loads drive `o_mem_mask` = 0000.
- Stores:
  - First word: mask = (size mask << offset)[3:0]; `o_mem_wdata` = `wdata << 8*offset`.
  - Second word of a split: mask = (size mask << offset)[7:4]; data = `wdata >> 8*(4-offset)`.
- Loads:
  - Form `{hi, lo}`, where `hi` is the second word (0 if not split).
  - Shift right by 8*offset and keep the size-width field.
  - B and H sign-extend; BU, HU and W zero-extend.
- Second word index is (word + 1) mod 256. 255 wraps to 0.
- Illegal `funct3`: no memory access; `o_fault` and `o_done` pulse the next cycle.
- FSM states:
  - IDLE: `o_ready` = 1. A split request moves to SPLIT2; everything else stays in IDLE.
  - SPLIT2: `o_ready` = 0. Issues the second access. For loads, captures the `lo` word from `i_mem_rdata` into a holding register. Returns to IDLE.
- Reset mid-operation: FSM goes to IDLE and all pulses clear. If a split store is interrupted, its first-half write stays in memory and the second half is never issued.

## Timing
- Reset values:
  - Outputs: `o_ready` 1; `o_rvalid`, `o_done`, `o_fault`, `o_mem_we` 0; `o_mem_mask` 0; `o_rdata` 0.
  - Internal state: FSM in IDLE; pending-load metadata cleared.
- Single-access request accepted at cycle T:
  - `o_done` pulses at T+1.
  - For a load, `o_rvalid` also pulses at T+1, with `o_rdata` formed combinationally from `i_mem_rdata` and the registered offset/size/sign.
- Throughput: one single-access request per cycle. `o_ready` stays high for back-to-back requests.
- Split request accepted at T:
  - Accesses at T and T+1; `o_ready` low at T+1.
  - `o_done` (and `o_rvalid` for a load) pulses at T+2.
  - A new request may be accepted at T+2.
- `o_rdata` is only meaningful while `o_rvalid` = 1.

## Configuration
- `LSU_MISALIGNED_EN` defined:
  - Non-natural, non-crossing accesses complete in one access.
  - Crossing accesses are split via SPLIT2.
  - `o_fault` is raised only for illegal `funct3`.
- `LSU_MISALIGNED_EN` undefined:
  - Any non-natural access faults with no memory access.
  - SPLIT2 and the holding register are not built; `o_ready` is constantly 1.

## Structure
- `lsu_pkg` contains:
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The FSM state typedef.
  - Functions for size-mask and legality decode.
- One sub-module, `lsu_ldext`: combinational `{hi, lo}`/offset/size/sign to 32-bit extended result.

## Test plan
- SW 0x010 data 0xDEADBEEF → `o_mem_we` 1, mask 1111, addr 4. Then LW 0x010 → at T+1 `o_rvalid` 1 and `o_rdata` 0xDEADBEEF.
- SB 0x013 data 0x000000A5 → mask 1000, `o_mem_wdata[31:24]` = 0xA5. Then LB 0x013 → 0xFFFFFFA5; LBU 0x013 → 0x000000A5.
- LW 0x000 then LW 0x004 in consecutive cycles → `o_rvalid` high for 2 consecutive cycles, `o_ready` never low.
- Word 1 = 0x44332211, word 2 = 0x88776655. LW 0x006:
  - With macro: `o_ready` low 1 cycle, result 0x66554433 at T+2.
  - Without macro: `o_fault` pulses at T+1, no `o_mem_we`.
- With macro, SH 0x3FF data 0x1234 → word 255 mask 1000 byte 0x34, then word 0 mask 0001 byte 0x12. `funct3` = 011 → `o_fault`, no access.
- `rst_n` low during SPLIT2 of a split store → all outputs at reset values, only the first half written, `o_ready` 1 after release.
